rvc_asap_dmem_rsp: RTL

Data-memory responder: the memory end of the core's load/store request/response interface.
- Accepts one request at a time, applies a programmable number of wait states, and commits writes or returns read data.
- Range and alignment violations are flagged with an error instead of an access.
- Sits between the core's memory stage and the D_MEM storage region 0x1000..D_MEM_MSB.

---
 rtl/rvc_asap_dmem_rsp_pkg.sv | 30 +++
 rtl/rvc_asap_dmem_array.sv | 30 +++
 rtl/rvc_asap_dmem_rsp.sv | 107 ++++++++++
 3 files changed

// File: rtl/rvc_asap_dmem_rsp_pkg.sv
// Shared types and constants for the data-memory responder: storage geometry,
// FSM states, the captured request record and the lane-legality rule.
package rvc_asap_dmem_rsp_pkg;

    localparam logic [31:0] DMEM_BASE  = 32'h0000_1000;
    localparam int          DMEM_WORDS = 1024;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } t_dmem_state;

    typedef struct packed {
        logic        wr_en;
        logic [31:0] addr;
        logic [3:0]  byte_en;
        logic [31:0] wr_data;
    } t_dmem_req;

    // Only naturally aligned byte, halfword and word accesses are legal.
    function automatic logic lanes_ok(input logic [1:0] addr_lo, input logic [3:0] byte_en);
        lanes_ok = (byte_en == (4'b0001 << addr_lo))
                || (byte_en == 4'b0011 && addr_lo == 2'b00)
                || (byte_en == 4'b1100 && addr_lo == 2'b10)
                || (byte_en == 4'b1111 && addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/rvc_asap_dmem_array.sv
// Word-organised data storage with per-byte write enables and a registered read
// port that holds its value until the next read.
module rvc_asap_dmem_array
    import rvc_asap_dmem_rsp_pkg::*;
#(
    parameter int WORDS = DMEM_WORDS,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    wr_be,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_be[k]) begin
                mem[addr][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/rvc_asap_dmem_rsp.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYCLES
// wait states, then commits the store or returns the aligned read word.
module rvc_asap_dmem_rsp #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] DMEM_BASE   = rvc_asap_dmem_rsp_pkg::DMEM_BASE,
    parameter logic [31:0] DMEM_LAST   = 32'h0000_1FFF
) (
    input  logic        QClk,
    input  logic        RstQnn,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrEn,
    input  logic [31:0] ReqAddr,
    input  logic [3:0]  ReqByteEn,
    input  logic [31:0] ReqWrData,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspRdData,
    output logic        RspErr
);
    import rvc_asap_dmem_rsp_pkg::*;

    localparam int         WORDS     = int'((DMEM_LAST - DMEM_BASE + 32'd1) >> 2);
    localparam int         AW        = $clog2(WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    t_dmem_state   state;
    t_dmem_state   state_nxt;
    t_dmem_req     req_q;
    logic [3:0]    wait_cnt;
    logic          err_q;
    logic          rd_ok_q;
    logic          accept;
    logic          access_err;
    logic          access_ok;
    logic [AW-1:0] word_idx;
    logic [3:0]    wr_be;
    logic          rd_en;
    logic [31:0]   rd_word;

    assign ReqReady = (state == IDLE) && RstQnn;
    assign accept   = ReqValid && ReqReady;

    // Range is checked on the full address so the index below is never used out of range.
    assign access_err = (req_q.addr < DMEM_BASE) || (req_q.addr > DMEM_LAST)
                     || !lanes_ok(req_q.addr[1:0], req_q.byte_en);
    assign word_idx   = AW'((req_q.addr - DMEM_BASE) >> 2);
    assign access_ok  = (state == ACCESS) && !access_err;
    assign wr_be      = (access_ok && req_q.wr_en) ? req_q.byte_en : 4'b0000;
    assign rd_en      = access_ok && !req_q.wr_en;

    always_ff @(posedge QClk or negedge RstQnn) begin
        if (!RstQnn) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            err_q    <= 1'b0;
            rd_ok_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == ACCESS) begin
                err_q   <= access_err;
                rd_ok_q <= rd_en;
            end
        end
    end

    // Request payload is plain data; it is only consumed after a qualified capture.
    always_ff @(posedge QClk) begin
        if (accept) begin
            req_q <= '{wr_en: ReqWrEn, addr: ReqAddr, byte_en: ReqByteEn, wr_data: ReqWrData};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ReqValid) state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            WAIT:    if (wait_cnt == 4'd0) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (RspReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    rvc_asap_dmem_array #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_array (
        .clk     (QClk),
        .addr    (word_idx),
        .wr_be   (wr_be),
        .wr_data (req_q.wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_word)
    );

    // The array holds its last read, so the response stays stable while stalled.
    assign RspValid  = (state == RESP);
    assign RspErr    = RspValid && err_q;
    assign RspRdData = (RspValid && rd_ok_q) ? rd_word : 32'd0;

endmodule
